// File: rtl/adder_pkg.sv
// adder_pkg
// Shared defaults and state encoding for the adder stream accumulator.
//   WIDTH_DEF : default operand / adder width
//   CNT_W_DEF : default width of the packet length and carry counter
//   state_e   : accumulator controller states (IDLE / ACC / DONE)
package adder_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : adder_pkg

// File: rtl/adder_accum_seq.sv
// adder_accum_seq
// Sums a packet of len_i operands using an external WIDTH-bit adder and
// returns the exact (WIDTH+CNT_W)-bit total as {res_carry_o, res_sum_o}.
// The adder is not instantiated here: add_a_o/add_b_o/add_cin_o feed it and
// add_sum_i/add_cout_i come back within the same cycle, so any adder
// architecture can be bound to these ports unchanged.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, len_i        packet start and operand count (sampled in IDLE)
//   op_valid_i/op_ready_o/op_data_i   operand stream
//   add_a_o, add_b_o, add_cin_o       to external adder
//   add_sum_i, add_cout_i             from external adder
//   res_valid_o/res_ready_i           result handshake
//   res_sum_o, res_carry_o            low word and carry count of the total
//   busy_o                            controller not idle
//
// Build option ADDER_ACC_INIT_EN: adds init_i, the accumulator seed loaded
// at packet start (otherwise the accumulator starts from 0).
module adder_accum_seq
   import adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
`ifdef ADDER_ACC_INIT_EN
   input  logic [WIDTH-1:0] init_i,
`endif
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [WIDTH-1:0] op_data_i,
   output logic [WIDTH-1:0] add_a_o,
   output logic [WIDTH-1:0] add_b_o,
   output logic             add_cin_o,
   input  logic [WIDTH-1:0] add_sum_i,
   input  logic             add_cout_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] res_sum_o,
   output logic [CNT_W-1:0] res_carry_o,
   output logic             busy_o
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [CNT_W-1:0] carry_q, carry_d;
   logic [CNT_W-1:0] rem_q,   rem_d;
   logic [WIDTH-1:0] acc_seed;

`ifdef ADDER_ACC_INIT_EN
   assign acc_seed = init_i;
`else
   assign acc_seed = '0;
`endif

   // Adder operands are driven in every state; the sum is only captured on
   // an operand handshake.
   assign add_a_o   = op_data_i;
   assign add_b_o   = acc_q;
   assign add_cin_o = 1'b0;

   // Handshake outputs decode state only, so there is no combinational path
   // from op_valid_i / res_ready_i back to the ready/valid outputs.
   assign op_ready_o  = (state_q == ST_ACC);
   assign res_valid_o = (state_q == ST_DONE);
   assign busy_o      = (state_q != ST_IDLE);
   assign res_sum_o   = acc_q;
   assign res_carry_o = carry_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      rem_d   = rem_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               acc_d   = acc_seed;
               carry_d = '0;
               rem_d   = len_i;
               state_d = (len_i == '0) ? ST_DONE : ST_ACC;
            end
         end
         ST_ACC: begin
            if (op_valid_i) begin
               acc_d   = add_sum_i;
               // At most one carry per addition and at most 2^CNT_W-1
               // additions, so the count cannot wrap.
               carry_d = carry_q + CNT_W'(add_cout_i);
               rem_d   = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // start_i deliberately ignored here, even alongside res_ready_i.
            if (res_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         carry_q <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         rem_q   <= rem_d;
      end
   end

endmodule : adder_accum_seq

// File: tb/tb_adder_accum_seq.sv
// tb_adder_accum_seq
// Bench for adder_accum_seq with a behavioural adder bound to the add_* ports.
// Expected totals are pushed to a scoreboard queue when a packet is launched
// and popped when the result handshake completes.
// Build option ADDER_ACC_INIT_EN enables the init_i seed scenario.
module tb_adder_accum_seq;

   localparam int WIDTH = 32;
   localparam int CNT_W = 8;
   localparam int TOT_W = WIDTH + CNT_W;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [CNT_W-1:0] len_i;
   logic [WIDTH-1:0] init_v;
   logic             op_valid_i;
   logic             op_ready_o;
   logic [WIDTH-1:0] op_data_i;
   logic [WIDTH-1:0] add_a_o;
   logic [WIDTH-1:0] add_b_o;
   logic             add_cin_o;
   logic [WIDTH-1:0] add_sum_i;
   logic             add_cout_i;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [WIDTH-1:0] res_sum_o;
   logic [CNT_W-1:0] res_carry_o;
   logic             busy_o;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] ops [0:255];
   logic [TOT_W-1:0] exp_q [$];

   always #5 clk_i = ~clk_i;

   // Stand-in for the external adder under test.
   assign {add_cout_i, add_sum_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {{WIDTH{1'b0}}, add_cin_o};

   adder_accum_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .len_i       (len_i),
`ifdef ADDER_ACC_INIT_EN
      .init_i      (init_v),
`endif
      .op_valid_i  (op_valid_i),
      .op_ready_o  (op_ready_o),
      .op_data_i   (op_data_i),
      .add_a_o     (add_a_o),
      .add_b_o     (add_b_o),
      .add_cin_o   (add_cin_o),
      .add_sum_i   (add_sum_i),
      .add_cout_i  (add_cout_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_sum_o   (res_sum_o),
      .res_carry_o (res_carry_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Runs one packet from IDLE using ops[0:len-1]; bubble_pct is the chance
   // of withholding op_valid_i per cycle, hold is cycles of res_ready_i low.
   task automatic run_packet(input int len, input int bubble_pct, input int hold);
      logic [TOT_W-1:0] tot;
      logic [TOT_W-1:0] exp_tot;
      int               i;
      int               cyc;
      logic             vld;
      logic             rdy;
      tot = {{CNT_W{1'b0}}, init_v};
      for (int k = 0; k < len; k++) tot = tot + {{CNT_W{1'b0}}, ops[k]};
      exp_q.push_back(tot);

      start_i = 1'b1;
      len_i   = CNT_W'(len);
      step();
      start_i = 1'b0;

      i   = 0;
      cyc = 0;
      while (i < len && cyc < 4000) begin
         vld        = ($urandom_range(0, 99) >= bubble_pct);
         op_valid_i = vld;
         op_data_i  = vld ? ops[i] : WIDTH'($urandom);
         // Starts during ACC must be ignored.
         start_i    = $urandom_range(0, 1) == 1;
         len_i      = CNT_W'($urandom_range(0, 255));
         rdy        = op_ready_o;
         step();
         if (vld && rdy) i++;
         cyc++;
      end
      if (i < len) chk("acc_timeout", 64'(i), 64'(len));
      op_valid_i = 1'b0;
      start_i    = 1'b0;

      // One cycle after the final handshake the result must be up.
      chk("res_valid_lat", 64'(res_valid_o), 64'd1);
      chk("done_ready_low", 64'(op_ready_o), 64'd0);

      for (int h = 0; h < hold; h++) begin
         op_valid_i = 1'b1;
         op_data_i  = WIDTH'($urandom);
         start_i    = 1'b1;
         step();
         chk("hold_valid", 64'(res_valid_o), 64'd1);
         chk("hold_ready", 64'(op_ready_o), 64'd0);
         chk("hold_total", 64'({res_carry_o, res_sum_o}), 64'(tot));
      end
      op_valid_i = 1'b0;

      // Result handshake with a coincident start that must be ignored.
      res_ready_i = 1'b1;
      start_i     = 1'b1;
      len_i       = 8'd3;
      if (res_valid_o && res_ready_i) begin
         if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
         end else begin
            exp_tot = exp_q.pop_front();
            chk("res_sum", 64'(res_sum_o), 64'(exp_tot[WIDTH-1:0]));
            chk("res_carry", 64'(res_carry_o), 64'(exp_tot[TOT_W-1:WIDTH]));
         end
      end else begin
         chk("res_valid_at_pop", 64'(res_valid_o), 64'd1);
      end
      step();
      res_ready_i = 1'b0;
      start_i     = 1'b0;
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("idle_valid", 64'(res_valid_o), 64'd0);
   endtask

   initial begin
      rst_i       = 1'b1;
      start_i     = 1'b0;
      len_i       = '0;
      init_v      = '0;
      op_valid_i  = 1'b0;
      op_data_i   = '0;
      res_ready_i = 1'b0;
      step();
      step();
      chk("rst_ready", 64'(op_ready_o), 64'd0);
      chk("rst_valid", 64'(res_valid_o), 64'd0);
      chk("rst_sum", 64'(res_sum_o), 64'd0);
      chk("rst_carry", 64'(res_carry_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      rst_i = 1'b0;
      step();

      // Reset mid-packet: two of four operands accepted, then reset.
      start_i = 1'b1;
      len_i   = 8'd4;
      step();
      start_i    = 1'b0;
      op_valid_i = 1'b1;
      op_data_i  = 32'h1234;
      step();
      step();
      rst_i = 1'b1;
      step();
      rst_i      = 1'b0;
      op_valid_i = 1'b0;
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_valid", 64'(res_valid_o), 64'd0);
      chk("midrst_sum", 64'(res_sum_o), 64'd0);
      chk("midrst_carry", 64'(res_carry_o), 64'd0);
      ops[0] = 32'h5;
      run_packet(1, 0, 0);

      // Basic back-to-back.
      ops[0] = 32'd1; ops[1] = 32'd2; ops[2] = 32'd3;
      run_packet(3, 0, 0);

      // Carry accumulation.
      for (int k = 0; k < 4; k++) ops[k] = 32'hFFFF_FFFF;
      run_packet(4, 0, 0);

      // Bubbles and result backpressure.
      for (int k = 0; k < 6; k++) ops[k] = $urandom;
      run_packet(6, 40, 5);

      // Zero-length packet.
      run_packet(0, 0, 2);

      // Maximum packet of all-ones.
      for (int k = 0; k < 255; k++) ops[k] = 32'hFFFF_FFFF;
      run_packet(255, 0, 0);

      // A few random packets.
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 20; k++) ops[k] = $urandom;
         run_packet($urandom_range(1, 20), 30, $urandom_range(0, 3));
      end

`ifdef ADDER_ACC_INIT_EN
      init_v = 32'hFFFF_FFF0;
      ops[0] = 32'h20;
      run_packet(1, 0, 0);
      run_packet(0, 0, 0);
      init_v = '0;
`endif

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_adder_accum_seq
